// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg
//   Shared types and constants for the JK bank driver.
//   - state_t    : controller states (IDLE, DRIVE, CHECK, ERR)
//   - JK_*       : per-bit excitation codes, packed as {J,K}
package jk_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_bank_driver_excite.sv
// jk_excite
//   Combinational JK excitation for one bit: which J/K to apply so that a
//   flip-flop currently holding q ends up holding t after one clock.
//   Macro JK_BANK_DRIVER_TOGGLE_EN: when defined, bits that must change are
//   toggled (J=K=1) instead of explicitly set or reset.
// Ports:
//   q : present Q of the flip-flop
//   t : wanted Q
//   j : J input to apply
//   k : K input to apply
module jk_excite
  import jk_bank_pkg::*;
(
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);

  logic [1:0] jk;

  always_comb begin
    jk = JK_HOLD;
    unique case ({q, t})
`ifdef JK_BANK_DRIVER_TOGGLE_EN
      2'b01:   jk = JK_TOGGLE;
      2'b10:   jk = JK_TOGGLE;
`else
      2'b01:   jk = JK_SET;
      2'b10:   jk = JK_RESET;
`endif
      default: jk = JK_HOLD;
    endcase
  end

  assign j = jk[1];
  assign k = jk[0];

endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver
//   Drives a bank of WIDTH external JK flip-flops (same clock) to a requested
//   target, reads the bank back, re-drives up to MAX_RETRY times on mismatch
//   and latches err when retries run out.
//   Macro JK_BANK_DRIVER_TOGGLE_EN selects toggle excitation (see jk_excite).
// Ports:
//   CLK        : clock, rising edge
//   RST_N      : asynchronous active-low reset
//   req_valid  : target request valid
//   req_ready  : block is in IDLE and can accept a request
//   req_target : value the bank must hold
//   q_fb       : Q outputs of the driven bank
//   J, K       : registered J/K inputs to the bank
//   done       : one-cycle pulse, bank matches target
//   err        : sticky, retries exhausted
//   err_clr    : clears err, returns to IDLE
//
// state | meaning
// IDLE  | ready for a request, J=K=0
// DRIVE | J/K asserted for one cycle, bank updates on the closing edge
// CHECK | J=K=0, compare q_fb with captured target
// ERR   | retries exhausted, waiting for err_clr
module jk_bank_driver
  import jk_bank_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(MAX_RETRY);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  retry_q, retry_d;
  logic [WIDTH-1:0]  j_d, k_d;
  logic              done_d;
  logic [WIDTH-1:0]  exc_t, exc_j, exc_k;

  // In IDLE the excitation is computed against the incoming request; in
  // CHECK (re-drive) against the captured target.
  assign exc_t = (state_q == IDLE) ? req_target : target_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_excite
    jk_excite u_excite (
      .q (q_fb[b]),
      .t (exc_t[b]),
      .j (exc_j[b]),
      .k (exc_k[b])
    );
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    j_d      = '0;
    k_d      = '0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          retry_d  = '0;
          j_d      = exc_j;
          k_d      = exc_k;
          state_d  = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (q_fb == target_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RETRY_LIM) begin
          retry_d = retry_q + CNT_W'(1);
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = DRIVE;
        end else begin
          state_d = ERR;
        end
      end
      ERR: begin
        if (err_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      target_q <= '0;
      retry_q  <= '0;
      J        <= '0;
      K        <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      J        <= j_d;
      K        <= k_d;
      done     <= done_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign err       = (state_q == ERR);

endmodule

// File: tb/tb_jk_bank_driver.sv
module tb_jk_bank_driver;

  localparam int W  = 4;
  localparam int MR = 2;

  logic         CLK;
  logic         RST_N;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_target;
  logic [W-1:0] J, K;
  logic         done;
  logic         err;
  logic         err_clr;

  // External JK bank model with optional faults
  logic [W-1:0] bank;
  logic         preload_en;
  logic [W-1:0] preload_val;
  int           preload_ign;
  int           ign_left;
  bit           stuck;

  int n_checks = 0;
  int n_fail   = 0;

  jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .q_fb       (bank),
    .J          (J),
    .K          (K),
    .done       (done),
    .err        (err),
    .err_clr    (err_clr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    if (preload_en) begin
      bank     <= preload_val;
      ign_left <= preload_ign;
    end else if (!stuck && (J | K) != '0) begin
      if (ign_left > 0) ign_left <= ign_left - 1;
      else              bank     <= (J & ~bank) | (~K & bank);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Excitation expected from the JK characteristic: set bits that must rise,
  // reset bits that must fall (or toggle both in the toggle build).
  function automatic logic [W-1:0] exp_j(input logic [W-1:0] q, input logic [W-1:0] t);
`ifdef JK_BANK_DRIVER_TOGGLE_EN
    return q ^ t;
`else
    return t & ~q;
`endif
  endfunction

  function automatic logic [W-1:0] exp_k(input logic [W-1:0] q, input logic [W-1:0] t);
`ifdef JK_BANK_DRIVER_TOGGLE_EN
    return q ^ t;
`else
    return q & ~t;
`endif
  endfunction

  task automatic preload(input logic [W-1:0] v, input bit s, input int ign);
    preload_val = v;
    preload_ign = ign;
    stuck       = s;
    preload_en  = 1'b1;
    @(negedge CLK);
    preload_en  = 1'b0;
  endtask

  // Entered at a negedge with req_valid=1 and req_target=t already presented.
  task automatic run_txn(input logic [W-1:0] t, input bit hold, input bit scramble,
                         input bit chain, input logic [W-1:0] next_t);
    logic [W-1:0] q0;
    int n;
    bit ok;
    int drives;
    check_eq("accept_ready", req_ready, 1);
    q0 = bank;
    if (q0 == t)                begin n = 1;            ok = 1'b1; end
    else if (stuck)             begin n = MR + 1;       ok = 1'b0; end
    else if (ign_left <= MR)    begin n = ign_left + 1; ok = 1'b1; end
    else                        begin n = MR + 1;       ok = 1'b0; end
    drives = 0;
    @(posedge CLK);
    for (int c = 0; c <= 2 * n; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        req_valid = hold;
        if (scramble) req_target = W'($urandom);
      end
      if ((J | K) != '0) drives++;
      if (c < 2 * n && (c % 2) == 0) begin
        check_eq("drive_j", J, exp_j(bank, t));
        check_eq("drive_k", K, exp_k(bank, t));
      end else begin
        check_eq("idle_j", J, 0);
        check_eq("idle_k", K, 0);
      end
      check_eq("done", done, (c == 2 * n) && ok);
      check_eq("ready", req_ready, (c == 2 * n) && ok);
      check_eq("err", err, (c == 2 * n) && !ok);
    end
    check_eq("drive_count", drives, (q0 == t) ? 0 : n);
    if (ok) begin
      check_eq("bank_final", bank, t);
      req_valid = chain;
      if (chain) req_target = next_t;
    end else begin
      check_eq("bank_held", bank, q0);
      req_valid  = 1'b1;
      req_target = W'($urandom);
      repeat (2) begin
        @(negedge CLK);
        check_eq("err_sticky", err, 1);
        check_eq("err_ready", req_ready, 0);
        check_eq("err_j", J, 0);
      end
      err_clr   = 1'b1;
      req_valid = 1'b0;
      @(posedge CLK);
      #1;
      check_eq("err_clr_err", err, 0);
      check_eq("err_clr_ready", req_ready, 1);
      @(negedge CLK);
      err_clr = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N       = 1'b0;
    req_valid   = 1'b0;
    req_target  = '0;
    err_clr     = 1'b0;
    preload_en  = 1'b0;
    preload_val = '0;
    preload_ign = 0;
    stuck       = 1'b0;

    @(negedge CLK);
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_j", J, 0);
    check_eq("rst_k", K, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    RST_N = 1'b1;

    // Set bits from zero
    preload(4'b0000, 1'b0, 0);
    req_valid = 1'b1; req_target = 4'b1010;
    @(posedge CLK); #1;
    check_eq("t1_j", J, exp_j(4'b0000, 4'b1010));
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("t1_bank", bank, 4'b1010);

    // Reset bits from ones
    preload(4'b1111, 1'b0, 0);
    req_valid = 1'b1; req_target = 4'b0110;
    run_txn(4'b0110, 1'b0, 1'b0, 1'b0, '0);

    // First drive ignored: one retry
    preload(4'b0000, 1'b0, 1);
    req_valid = 1'b1; req_target = 4'b0011;
    run_txn(4'b0011, 1'b0, 1'b0, 1'b0, '0);

    // Stuck bank: retries exhausted, err
    preload(4'b0000, 1'b1, 0);
    req_valid = 1'b1; req_target = 4'b0001;
    run_txn(4'b0001, 1'b0, 1'b0, 1'b0, '0);

    // Reset during DRIVE
    preload(4'b0000, 1'b0, 0);
    req_valid = 1'b1; req_target = 4'b1111;
    @(posedge CLK); #2;
    check_eq("rstmid_drive_j", J, 4'b1111);
    RST_N = 1'b0;
    #1;
    check_eq("rstmid_j", J, 0);
    check_eq("rstmid_k", K, 0);
    check_eq("rstmid_done", done, 0);
    req_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_eq("rstmid_bank", bank, 4'b0000);
    RST_N = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check_eq("rstmid_no_done", done, 0);
      check_eq("rstmid_ready", req_ready, 1);
    end

    // Back-to-back with req_valid held
    preload(4'b0000, 1'b0, 0);
    req_valid = 1'b1; req_target = 4'b0101;
    run_txn(4'b0101, 1'b1, 1'b0, 1'b1, 4'b1100);
    run_txn(4'b1100, 1'b1, 1'b0, 1'b0, '0);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] tv;
      preload(W'($urandom), ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)));
      tv = W'($urandom);
      req_valid = 1'b1; req_target = tv;
      run_txn(tv, bit'($urandom_range(0, 1)), 1'b1, 1'b0, '0);
      if ($urandom_range(0, 1) == 1) @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
